// File: rtl/pipe_reg_lane_sched_pkg.sv
// Shared types and defaults for the pipeline-register lane load scheduler.
package pipe_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam int LANES_DEF  = 16;
  localparam int LANE_IDX_W = $clog2(LANES_DEF);

endpackage

// File: rtl/pipe_reg_lane_sched_if.sv
// BRAM read-port and tile handshake bundle between the scheduler and its neighbours.
// rd_en/rd_gnt: a read issues on every cycle where both are high; until then rd_en and
// rd_addr hold. tile_valid/tile_ack: tile_valid stays high until tile_ack is seen with it.
interface pipe_reg_lane_sched_if #(
  parameter int LANES  = 16,
  parameter int ADDR_W = 12
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic [LANES-1:0]  valid_data;
  logic              tile_valid;
  logic              tile_ack;

  modport master (
    output rd_en, rd_addr, valid_data, tile_valid,
    input  rd_gnt, tile_ack
  );

  modport slave (
    input  rd_en, rd_addr, valid_data, tile_valid,
    output rd_gnt, tile_ack
  );
endinterface

// File: rtl/pipe_reg_lane_sched_rd_return_pipe.sv
// Tracks granted BRAM reads for RD_LAT cycles and turns each returning lane index
// into a registered one-hot load enable for the pipeline register.
module rd_return_pipe
  import pipe_sched_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int RD_LAT = 2,
  localparam int IDX_W = $clog2(LANES)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [IDX_W-1:0] push_idx,
  output logic [LANES-1:0] valid_data,
  output logic             empty
);

  logic             fin_v;
  logic [IDX_W-1:0] fin_idx;
  logic [LANES-1:0] valid_d, valid_q;

  // The last latency cycle is the one-hot output register itself, so only
  // RD_LAT-1 tracking stages are needed; "empty" means none of them hold a read.
  generate
    if (RD_LAT == 1) begin : g_direct
      assign fin_v   = push;
      assign fin_idx = push_idx;
      assign empty   = 1'b1;
    end else begin : g_stages
      localparam int STG = RD_LAT - 1;
      logic [STG-1:0]   vld_d, vld_q;
      logic [IDX_W-1:0] idx_d [STG];
      logic [IDX_W-1:0] idx_q [STG];

      always_comb begin
        vld_d[0] = push;
        idx_d[0] = push_idx;
        for (int i = 1; i < STG; i++) begin
          vld_d[i] = vld_q[i-1];
          idx_d[i] = idx_q[i-1];
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          vld_q <= '0;
          for (int i = 0; i < STG; i++) idx_q[i] <= '0;
        end else begin
          vld_q <= vld_d;
          for (int i = 0; i < STG; i++) idx_q[i] <= idx_d[i];
        end
      end

      assign fin_v   = vld_q[STG-1];
      assign fin_idx = idx_q[STG-1];
      assign empty   = ~|vld_q;
    end
  endgenerate

  always_comb begin
    valid_d = '0;
    if (fin_v) valid_d[fin_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) valid_q <= '0;
    else          valid_q <= valid_d;
  end

  assign valid_data = valid_q;

endmodule

// File: rtl/pipe_reg_lane_sched.sv
// Load scheduler: issues one strided BRAM read per requested lane, pulses the matching
// lane enable when its byte returns, then holds tile_valid until the PE array acks.
module pipe_reg_lane_sched
  import pipe_sched_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int ADDR_W = 12,
  parameter int RD_LAT = 2,
  localparam int IDX_W = $clog2(LANES)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      base_addr,
  input  logic [ADDR_W-1:0]      stride,
  input  logic [4:0]             num_lanes,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output state_t                 dbg_state,
  pipe_reg_lane_sched_if.master  bus
);

  state_t            state_d, state_q;
  logic [4:0]        lane_d, lane_q;
  logic [4:0]        num_d, num_q;
  logic [ADDR_W-1:0] stride_d, stride_q;
  logic [ADDR_W-1:0] rd_addr_d, rd_addr_q;
  logic              rd_en_d, rd_en_q;
  logic              busy_d, busy_q;
  logic              tile_valid_d, tile_valid_q;
  logic              done_d, done_q;
  logic              err_d, err_q;

  logic              push;
  logic [IDX_W-1:0]  push_idx;
  logic              pipe_empty;
  logic              num_legal;

  assign num_legal = (num_lanes != 5'd0) && (num_lanes <= 5'(LANES));

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    num_d     = num_q;
    stride_d  = stride_q;
    rd_addr_d = rd_addr_q;
    rd_en_d   = rd_en_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    push      = 1'b0;
    push_idx  = lane_q[IDX_W-1:0];

    case (state_q)
      IDLE: begin
        if (start) begin
          if (num_legal) begin
            num_d     = num_lanes;
            stride_d  = stride;
            lane_d    = 5'd0;
            rd_addr_d = base_addr;
            rd_en_d   = 1'b1;
            state_d   = ISSUE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (bus.rd_gnt) begin
          push      = 1'b1;
          lane_d    = lane_q + 5'd1;
          rd_addr_d = rd_addr_q + stride_q;
          if (lane_q == num_q - 5'd1) begin
            rd_en_d = 1'b0;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pipe_empty) state_d = HOLD;
      end
      HOLD: begin
        if (bus.tile_ack) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d       = (state_d != IDLE);
    tile_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      lane_q       <= '0;
      num_q        <= '0;
      stride_q     <= '0;
      rd_addr_q    <= '0;
      rd_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      tile_valid_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      num_q        <= num_d;
      stride_q     <= stride_d;
      rd_addr_q    <= rd_addr_d;
      rd_en_q      <= rd_en_d;
      busy_q       <= busy_d;
      tile_valid_q <= tile_valid_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  rd_return_pipe #(
    .LANES  (LANES),
    .RD_LAT (RD_LAT)
  ) u_ret (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (push),
    .push_idx   (push_idx),
    .valid_data (bus.valid_data),
    .empty      (pipe_empty)
  );

  assign bus.rd_en      = rd_en_q;
  assign bus.rd_addr    = rd_addr_q;
  assign bus.tile_valid = tile_valid_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_pipe_reg_lane_sched.sv
// Directed bench for pipe_reg_lane_sched with a timestamped return-data scoreboard.
module tb_pipe_reg_lane_sched;
  import pipe_sched_pkg::*;

  localparam int LANES  = 16;
  localparam int ADDR_W = 12;
  localparam int RD_LAT = 2;

  logic              clk;
  logic              reset_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] stride;
  logic [4:0]        num_lanes;
  logic              busy;
  logic              done;
  logic              err;
  state_t            dbg_state;

  pipe_reg_lane_sched_if #(.LANES(LANES), .ADDR_W(ADDR_W)) bus ();

  pipe_reg_lane_sched #(.LANES(LANES), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .base_addr (base_addr),
    .stride    (stride),
    .num_lanes (num_lanes),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state),
    .bus       (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // scoreboard: expected one-hot enable and the cycle it must appear in
  logic [LANES-1:0] exp_q[$];
  int               exp_t_q[$];

  int m_base, m_stride, m_num, m_lane;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // advance to the next cycle, 2 time units after the active edge (input drive point)
  task automatic next();
    @(posedge clk);
    #2;
    cyc++;
  endtask

  // move to the falling edge and run the per-cycle scoreboard checks
  task automatic smp();
    logic [ADDR_W-1:0] exp_a;
    logic [LANES-1:0]  one;
    @(negedge clk);
    if (exp_t_q.size() > 0 && exp_t_q[0] == cyc) begin
      chk("valid_data_ret", 32'(bus.valid_data), 32'(exp_q.pop_front()));
      void'(exp_t_q.pop_front());
    end else begin
      chk("valid_data_idle", 32'(bus.valid_data), 32'd0);
    end
    if (bus.rd_en && bus.rd_gnt) begin
      exp_a = ADDR_W'(m_base + m_lane * m_stride);
      chk("rd_addr_issue", 32'(bus.rd_addr), 32'(exp_a));
      chk("rd_en_in_range", 32'(bus.rd_en), 32'(m_lane < m_num));
      one = '0;
      if (m_lane < LANES) one[m_lane] = 1'b1;
      exp_q.push_back(one);
      exp_t_q.push_back(cyc + RD_LAT);
      m_lane++;
    end
  endtask

  task automatic load(input int b, input int s, input int n);
    start     = 1'b1;
    base_addr = ADDR_W'(b);
    stride    = ADDR_W'(s);
    num_lanes = 5'(n);
    m_base    = b;
    m_stride  = s;
    m_num     = n;
    m_lane    = 0;
  endtask

  initial begin
    logic [ADDR_W-1:0] wrap_tab [4];
    int bad_n [2];
    wrap_tab[0] = 12'hFFE; wrap_tab[1] = 12'hFFF; wrap_tab[2] = 12'h000; wrap_tab[3] = 12'h001;
    bad_n[0] = 0; bad_n[1] = 17;

    reset_n = 1'b1; start = 1'b0; base_addr = '0; stride = '0; num_lanes = '0;
    bus.rd_gnt = 1'b1; bus.tile_ack = 1'b0;
    m_base = 0; m_stride = 0; m_num = 0; m_lane = 0;
    #1 reset_n = 1'b0;
    #2;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rd_en", 32'(bus.rd_en), 0);
    chk("rst_rd_addr", 32'(bus.rd_addr), 0);
    chk("rst_valid", 32'(bus.valid_data), 0);
    chk("rst_tile_valid", 32'(bus.tile_valid), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    next(); smp();
    next(); reset_n = 1'b1; smp();

    // full 16-lane load, grant always high; a start while busy must be ignored
    next(); load(32'h100, 4, 16); smp();
    for (int c = 1; c <= 21; c++) begin
      next();
      start        = (c == 5);
      num_lanes    = 5'd0;
      bus.tile_ack = (c == 20);
      smp();
      chk("t1_rd_en", 32'(bus.rd_en), 32'(c >= 1 && c <= 16));
      if (c >= 1 && c <= 16) chk("t1_rd_addr", 32'(bus.rd_addr), 32'h100 + 32'(4 * (c - 1)));
      if (c == 3)  chk("t1_first_lane", 32'(bus.valid_data), 32'h0001);
      if (c == 18) chk("t1_last_lane", 32'(bus.valid_data), 32'h8000);
      if (c == 19) chk("t1_state_hold", 32'(dbg_state), 32'(HOLD));
      chk("t1_tile_valid", 32'(bus.tile_valid), 32'(c >= 19 && c <= 20));
      chk("t1_busy", 32'(busy), 32'(c <= 20));
      chk("t1_err", 32'(err), 0);
      chk("t1_done", 32'(done), 32'(c == 21));
    end
    chk("t1_sb_drained", exp_q.size(), 0);

    // 3 lanes, one missing grant in cycle 2
    next(); load(32'h200, 8, 3); smp();
    for (int c = 1; c <= 9; c++) begin
      next();
      start        = 1'b0;
      bus.rd_gnt   = (c != 2);
      bus.tile_ack = (c == 7);
      smp();
      chk("t2_rd_en", 32'(bus.rd_en), 32'(c >= 1 && c <= 4));
      if (c == 1) chk("t2_rd_addr_l0", 32'(bus.rd_addr), 32'h200);
      if (c == 2 || c == 3) chk("t2_rd_addr_held", 32'(bus.rd_addr), 32'h208);
      if (c == 4) chk("t2_rd_addr_l2", 32'(bus.rd_addr), 32'h210);
      if (c == 5) chk("t2_lane1_ret", 32'(bus.valid_data), 32'h0002);
      chk("t2_tile_valid", 32'(bus.tile_valid), 32'(c == 7));
      chk("t2_done", 32'(done), 32'(c == 8));
    end
    bus.rd_gnt = 1'b1;
    chk("t2_sb_drained", exp_q.size(), 0);

    // address wrap
    next(); load(32'hFFE, 1, 4); smp();
    for (int c = 1; c <= 8; c++) begin
      next();
      start        = 1'b0;
      bus.tile_ack = (c == 7);
      smp();
      if (c <= 4) chk("t3_rd_addr_wrap", 32'(bus.rd_addr), 32'(wrap_tab[c-1]));
      chk("t3_tile_valid", 32'(bus.tile_valid), 32'(c == 7));
      chk("t3_done", 32'(done), 32'(c == 8));
    end
    chk("t3_sb_drained", exp_q.size(), 0);

    // illegal lane counts
    for (int k = 0; k < 2; k++) begin
      next(); start = 1'b1; num_lanes = 5'(bad_n[k]); smp();
      next(); start = 1'b0; smp();
      chk("t4_err_pulse", 32'(err), 1);
      chk("t4_rd_en", 32'(bus.rd_en), 0);
      chk("t4_busy", 32'(busy), 0);
      next(); smp();
      chk("t4_err_clear", 32'(err), 0);
      chk("t4_rd_en_after", 32'(bus.rd_en), 0);
      chk("t4_busy_after", 32'(busy), 0);
    end

    // ack held from the start; back-to-back start in the done cycle
    next(); load(32'h040, 2, 2); bus.tile_ack = 1'b1; smp();
    for (int c = 1; c <= 11; c++) begin
      next();
      start = 1'b0;
      if (c == 6) load(32'h080, 1, 1);
      bus.tile_ack = (c <= 5) || (c == 10);
      smp();
      chk("t5_rd_en", 32'(bus.rd_en), 32'(c == 1 || c == 2 || c == 7));
      chk("t5_tile_valid", 32'(bus.tile_valid), 32'(c == 5 || c == 10));
      chk("t5_done", 32'(done), 32'(c == 6 || c == 11));
      chk("t5_busy", 32'(busy), 32'((c >= 1 && c <= 5) || (c >= 7 && c <= 10)));
    end
    chk("t5_sb_drained", exp_q.size(), 0);

    // reset in ISSUE with reads in flight
    next(); load(32'h300, 8, 8); smp();
    next(); start = 1'b0; smp();
    next(); smp();
    next();
    reset_n = 1'b0;
    exp_q.delete();
    exp_t_q.delete();
    m_num = 0;
    #1;
    chk("t6_busy", 32'(busy), 0);
    chk("t6_rd_en", 32'(bus.rd_en), 0);
    chk("t6_rd_addr", 32'(bus.rd_addr), 0);
    chk("t6_valid", 32'(bus.valid_data), 0);
    chk("t6_tile_valid", 32'(bus.tile_valid), 0);
    chk("t6_state", 32'(dbg_state), 32'(IDLE));
    smp();
    next(); smp();
    next(); reset_n = 1'b1; smp();
    for (int k = 0; k < RD_LAT + 2; k++) begin
      next(); smp();
      chk("t6_valid_after", 32'(bus.valid_data), 0);
      chk("t6_rd_en_after", 32'(bus.rd_en), 0);
      chk("t6_busy_after", 32'(busy), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
